// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq_4_if.sv
// Soft-reset handshake and reset-output bundle for the staged reset sequencer.
//   SRST_REQ : soft-reset request (level, four-phase with SRST_ACK)
//   SRST_ACK : soft-reset acknowledge
//   RNO[3:0] : sequenced active-low reset outputs, bit 0 released first
//   RDY      : high once every RNO bit is released
// The sequencer is the slave: it answers the request and drives the resets.
interface gf180mcu_fd_sc_mcu9t5v0__rstseq_4_if;
  logic       SRST_REQ;
  logic       SRST_ACK;
  logic [3:0] RNO;
  logic       RDY;

  modport master (output SRST_REQ, input SRST_ACK, input RNO, input RDY);
  modport slave  (input SRST_REQ, output SRST_ACK, output RNO, output RDY);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq_4.sv
// Staged reset generator. RN asserts every output asynchronously; release is
// synchronized through a SYNC_STAGES-deep flop chain, held for HOLD_CYCLES,
// then RNO[0..3] are released one by one STAGE_GAP cycles apart. Once all
// bits are released RDY rises, and a soft reset may be requested through a
// four-phase SRST_REQ/SRST_ACK handshake, which restarts at the hold phase.
// Ports:
//   CLK : clock, all state changes on its rising edge
//   RN  : asynchronous active-low reset
//   bus : slave modport carrying SRST_REQ, SRST_ACK, RNO and RDY
// Parameters: SYNC_STAGES 2..4, HOLD_CYCLES 1..255, STAGE_GAP 1..255.
module gf180mcu_fd_sc_mcu9t5v0__rstseq_4 #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic                                  CLK,
  input  logic                                  RN,
  gf180mcu_fd_sc_mcu9t5v0__rstseq_4_if.slave    bus
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_STAGE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [7:0]               cnt_q, cnt_d;
  logic [1:0]               idx_q, idx_d;
  logic [3:0]               rno_q, rno_d;
  logic                     rdy_q, rdy_d;
  logic                     ack_q, ack_d;
  logic                     rearm_q, rearm_d;
  logic                     accept;
  logic                     sync_done;

  // Release synchronizer: shifts in 1 after RN deasserts.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // HOLD is entered on the edge the last stage captures 1, so that RNO[0]
  // rises exactly SYNC_STAGES+HOLD_CYCLES edges after RN release.
  assign sync_done = sync_q[SYNC_STAGES-2] | sync_q[SYNC_STAGES-1];

  // A soft reset is only taken when fully released and the request has been
  // seen low since the last acceptance (or since reset).
  assign accept = (state_q == ST_DONE) && bus.SRST_REQ && rearm_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      rno_q   <= '0;
      rdy_q   <= 1'b0;
      ack_q   <= 1'b0;
      rearm_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rno_q   <= rno_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      rearm_q <= rearm_d;
    end
  end

  // NOTE: every variable gets its hold value first, so no branch can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rno_d   = rno_q;
    rdy_d   = rdy_q;
    ack_d   = ack_q;
    rearm_d = rearm_q;

    unique case (state_q)
      ST_SYNC: begin
        if (sync_done) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          rno_d[0] = 1'b1;
          idx_d    = 2'd1;
          cnt_d    = GAP_LOAD;
          state_d  = ST_STAGE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_STAGE: begin
        if (cnt_q == 8'd0) begin
          rno_d[idx_q] = 1'b1;
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 2'd1;
            cnt_d = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        if (accept) begin
          rno_d   = 4'b0000;
          rdy_d   = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          rdy_d = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // Handshake: ACK holds until the request is seen low, which also re-arms.
    // A request seen high outside DONE disarms, so a request held since
    // power-up (or since mid-sequence) must drop before it can be accepted.
    if (accept) begin
      ack_d   = 1'b1;
      rearm_d = 1'b0;
    end else if (!bus.SRST_REQ) begin
      ack_d   = 1'b0;
      rearm_d = 1'b1;
    end else if (state_q != ST_DONE) begin
      rearm_d = 1'b0;
    end
  end

  assign bus.RNO      = rno_q;
  assign bus.RDY      = rdy_q;
  assign bus.SRST_ACK = ack_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rstseq_4.sv
// Directed bench for the staged reset generator: a default instance (a) and a
// fast instance (b: SYNC_STAGES=3, HOLD_CYCLES=1, STAGE_GAP=1) share CLK/RN.
module tb_gf180mcu_fd_sc_mcu9t5v0__rstseq_4;

  logic clk;
  logic rn;
  int   edge_n;
  int   n_checks;
  int   n_fail;

  gf180mcu_fd_sc_mcu9t5v0__rstseq_4_if a_if ();
  gf180mcu_fd_sc_mcu9t5v0__rstseq_4_if b_if ();

  gf180mcu_fd_sc_mcu9t5v0__rstseq_4 dut_a (
    .CLK (clk),
    .RN  (rn),
    .bus (a_if)
  );

  gf180mcu_fd_sc_mcu9t5v0__rstseq_4 #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1),
    .STAGE_GAP   (1)
  ) dut_b (
    .CLK (clk),
    .RN  (rn),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic       req;
    logic [3:0] rno_a;
    logic       rdy_a;
    logic       ack_a;
    logic [3:0] rno_b;
    logic       rdy_b;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic advance_to(input int n);
    while (edge_n < n) tick();
  endtask

  // Assert RN between edges, check the asynchronous clear, release again.
  // The next rising edge becomes edge 1.
  task automatic do_reset(input string tag);
    rn = 1'b0;
    #2;
    check({tag, " rno_a"}, a_if.RNO, 4'b0000);
    check({tag, " rdy_a"}, a_if.RDY, 1'b0);
    check({tag, " ack_a"}, a_if.SRST_ACK, 1'b0);
    check({tag, " rno_b"}, b_if.RNO, 4'b0000);
    rn = 1'b1;
    edge_n = 0;
  endtask

  logic [3:0] prev_rno;
  int         e;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    edge_n   = 0;
    a_if.SRST_REQ = 1'b0;
    b_if.SRST_REQ = 1'b0;
    rn = 1'b1;
    #2 rn = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Default: RNO at 18/22/26/30, RDY at 31. Fast: RNO at 4..7, RDY at 8.
    // SRST_REQ to (a) is high for edges 20..22 while in STAGE and is ignored.
    //             edge req rno_a   rdy  ack  rno_b   rdy_b
    tbl.push_back('{1,  1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{3,  1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{4,  1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0});
    tbl.push_back('{5,  1'b0, 4'b0000, 1'b0, 1'b0, 4'b0011, 1'b0});
    tbl.push_back('{6,  1'b0, 4'b0000, 1'b0, 1'b0, 4'b0111, 1'b0});
    tbl.push_back('{7,  1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0});
    tbl.push_back('{8,  1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{17, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{18, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{19, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{20, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{21, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{22, 1'b1, 4'b0011, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{25, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{26, 1'b0, 4'b0111, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{29, 1'b0, 4'b0111, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{30, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{31, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{34, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1});

    do_reset("por");
    prev_rno = 4'b0000;
    foreach (tbl[i]) begin
      a_if.SRST_REQ = tbl[i].req;
      while (edge_n < tbl[i].edge_no) begin
        tick();
        check("rno_a monotonic", a_if.RNO & prev_rno, prev_rno);
        prev_rno = a_if.RNO;
      end
      check("tbl rno_a", a_if.RNO, tbl[i].rno_a);
      check("tbl rdy_a", a_if.RDY, tbl[i].rdy_a);
      check("tbl ack_a", a_if.SRST_ACK, tbl[i].ack_a);
      check("tbl rno_b", b_if.RNO, tbl[i].rno_b);
      check("tbl rdy_b", b_if.RDY, tbl[i].rdy_b);
    end
    a_if.SRST_REQ = 1'b0;

    // RN pulsed low for 1 ns after edge 24, then a full restart.
    do_reset("restart");
    advance_to(24);
    check("pre-pulse rno_a", a_if.RNO, 4'b0011);
    #2 rn = 1'b0;
    #1;
    check("pulse rno_a", a_if.RNO, 4'b0000);
    check("pulse rdy_a", a_if.RDY, 1'b0);
    rn = 1'b1;
    edge_n = 0;
    advance_to(17);
    check("post-pulse e17 rno_a", a_if.RNO, 4'b0000);
    advance_to(18);
    check("post-pulse e18 rno_a", a_if.RNO, 4'b0001);
    advance_to(30);
    check("post-pulse e30 rno_a", a_if.RNO, 4'b1111);
    check("post-pulse e30 rdy_a", a_if.RDY, 1'b0);
    advance_to(31);
    check("post-pulse e31 rdy_a", a_if.RDY, 1'b1);

    // Soft reset in DONE; request dropped after two more edges.
    a_if.SRST_REQ = 1'b1;
    tick();
    e = edge_n;
    check("srst accept rno_a", a_if.RNO, 4'b0000);
    check("srst accept rdy_a", a_if.RDY, 1'b0);
    check("srst accept ack_a", a_if.SRST_ACK, 1'b1);
    advance_to(e + 2);
    check("srst ack held", a_if.SRST_ACK, 1'b1);
    a_if.SRST_REQ = 1'b0;
    tick();
    check("srst ack cleared", a_if.SRST_ACK, 1'b0);
    advance_to(e + 15);
    check("srst E+15 rno_a", a_if.RNO, 4'b0000);
    advance_to(e + 16);
    check("srst E+16 rno_a", a_if.RNO, 4'b0001);
    advance_to(e + 20);
    check("srst E+20 rno_a", a_if.RNO, 4'b0011);
    advance_to(e + 24);
    check("srst E+24 rno_a", a_if.RNO, 4'b0111);
    advance_to(e + 28);
    check("srst E+28 rno_a", a_if.RNO, 4'b1111);
    check("srst E+28 rdy_a", a_if.RDY, 1'b0);
    advance_to(e + 29);
    check("srst E+29 rdy_a", a_if.RDY, 1'b1);

    // Request held high across the end of the soft-reset sequence.
    a_if.SRST_REQ = 1'b1;
    tick();
    e = edge_n;
    check("held accept rno_a", a_if.RNO, 4'b0000);
    advance_to(e + 32);
    check("held no second rno_a", a_if.RNO, 4'b1111);
    check("held no second rdy_a", a_if.RDY, 1'b1);
    check("held ack_a", a_if.SRST_ACK, 1'b1);
    a_if.SRST_REQ = 1'b0;
    tick();
    check("held release ack_a", a_if.SRST_ACK, 1'b0);
    check("held release rno_a", a_if.RNO, 4'b1111);

    // Request high from power-up: only a fresh rise after a fall is accepted.
    a_if.SRST_REQ = 1'b1;
    do_reset("req-at-por");
    advance_to(31);
    check("por-req e31 rdy_a", a_if.RDY, 1'b1);
    check("por-req e31 ack_a", a_if.SRST_ACK, 1'b0);
    advance_to(35);
    check("por-req e35 rno_a", a_if.RNO, 4'b1111);
    check("por-req e35 ack_a", a_if.SRST_ACK, 1'b0);
    a_if.SRST_REQ = 1'b0;
    tick();
    check("por-req low ack_a", a_if.SRST_ACK, 1'b0);
    a_if.SRST_REQ = 1'b1;
    tick();
    check("por-req rise ack_a", a_if.SRST_ACK, 1'b1);
    check("por-req rise rno_a", a_if.RNO, 4'b0000);
    check("por-req rise rdy_a", a_if.RDY, 1'b0);
    a_if.SRST_REQ = 1'b0;
    tick();
    check("por-req drop ack_a", a_if.SRST_ACK, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__rstseq_4.md
GF180MCU_FD_SC_MCU9T5V0__RSTSEQ_4 -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__rstseq_4

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of reset-release synchronizer flops; legal range 2..4.
REQ-002 Parameter HOLD_CYCLES, default 16, SHALL set the number of clock cycles between synchronized release and RNO[0] rising; legal range 1..255.
REQ-003 Parameter STAGE_GAP, default 4, SHALL set the number of cycles between successive RNO bits rising; legal range 1..255.
REQ-004 CLK  input  1  SHALL be the single clock; all state changes on its rising edge, except asynchronous reset.
REQ-005 RN  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 SRST_REQ  input  1  SHALL be the soft-reset request, level, four-phase handshake with SRST_ACK.
REQ-007 RNO  output  4  SHALL be the sequenced active-low reset outputs that drive downstream RN pins, bit 0 released first.
REQ-008 RDY  output  1  SHALL be high only when all RNO bits are released.
REQ-009 SRST_ACK  output  1  SHALL be the soft-reset acknowledge.

Function
REQ-010 The block SHALL be a reset generator: asynchronous assertion and synchronous, staged deassertion of RNO.
REQ-011 The FSM SHALL have the states SYNC, HOLD, STAGE and DONE; an 8-bit down-counter SHALL provide the HOLD and STAGE timing, and a 2-bit index SHALL track the next RNO bit.
REQ-012 SYNC: an SYNC_STAGES-deep flop chain, cleared by RN, SHALL shift in 1; when its last stage is 1, the FSM SHALL enter HOLD with counter=HOLD_CYCLES-1.
REQ-013 HOLD: the counter SHALL decrement each cycle; at 0, RNO[0] SHALL go to 1, index=1, and the FSM SHALL enter STAGE with counter=STAGE_GAP-1.
REQ-014 STAGE: at counter 0, RNO[index] SHALL go to 1; the FSM SHALL stay in STAGE and reload the counter if index<3, and SHALL enter DONE if index=3.
REQ-015 DONE: RDY SHALL register to 1 on the first edge in DONE.
REQ-016 Edge numbering: edge 1 is the first rising CLK with RN high. RNO[k] SHALL rise on edge SYNC_STAGES+HOLD_CYCLES+k*STAGE_GAP. RDY SHALL rise one edge after RNO[3].
REQ-017 RNO bits SHALL only rise in index order; a bit SHALL never fall while RN is high except by a soft reset.
REQ-018 Soft reset accept: when SRST_REQ=1 and the re-arm flag is set in DONE, that edge SHALL set RNO=4'b0000, RDY=0, SRST_ACK=1 and clear the re-arm flag.
REQ-019 After a soft-reset accept, the FSM SHALL enter HOLD with counter=HOLD_CYCLES-1 and bypass SYNC; release timing SHALL then follow REQ-013/014 with the accept edge as origin.
REQ-020 SRST_ACK SHALL stay 1 until SRST_REQ is sampled 0, then clear on that edge; the re-arm flag SHALL be set by sampling SRST_REQ=0.
REQ-021 SRST_REQ SHALL be ignored, with no ACK and no effect, outside DONE or while the re-arm flag is clear.
REQ-022 If SRST_REQ is held high across the end of a sequence, no second soft reset SHALL occur.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from SRST_REQ to any output.

Reset
REQ-024 RN=0 SHALL immediately and asynchronously force RNO=4'b0000, RDY=0, SRST_ACK=0, the synchronizer to all zeros, the counter and index to 0, the re-arm flag to 1, and the FSM to SYNC.
REQ-025 RN falling mid-sequence, including during a soft reset, SHALL abort the sequence with the REQ-024 values; release SHALL restart from SYNC.
REQ-026 RN deassertion SHALL never release any RNO bit sooner than REQ-016 specifies.

Verification
REQ-027 Defaults, RN rises, SRST_REQ=0 -> RNO[0] at edge 18, RNO[1] at 22, RNO[2] at 26, RNO[3] at 30, RDY at 31; RNO monotonic throughout.
REQ-028 RN pulsed low for 1 ns between edges at edge 24 -> RNO=0000 and RDY=0 with no clock edge, then the full sequence repeats from a new edge 1.
REQ-029 In DONE, SRST_REQ rises before edge E -> at E: RNO=0000, RDY=0, ACK=1; RNO[0] at E+16 … RDY at E+29; ACK clears on the edge after SRST_REQ falls.
REQ-030 SRST_REQ held high from power-up through DONE -> no ACK and no soft reset; the request is accepted only after SRST_REQ falls and rises again.
REQ-031 Parameters SYNC_STAGES=3, HOLD_CYCLES=1, STAGE_GAP=1 -> RNO bits rise on edges 4, 5, 6, 7 and RDY on edge 8.
REQ-032 SRST_REQ asserted at edge 20 with defaults (in STAGE) -> ignored, no ACK, and the sequence timing is unchanged.
